// File: rtl/wave_delay_trigger_if.sv
// Write-stream and trigger/fire signal bundle for wave_delay_trigger.
// master drives the table writes and triggers; slave is the scheduler.
interface wave_delay_trigger_if #(
  parameter int ADDR_W  = 11,
  parameter int DELAY_W = 24
);
  logic               I_WEA;
  logic [ADDR_W-1:0]  I_WRITE_ADDR;
  logic [DELAY_W-1:0] I_WRITE_DELAY;
  logic               I_trig;
  logic [ADDR_W-1:0]  I_wave_id;
  logic               O_busy;
  logic               O_fire;
  logic [ADDR_W-1:0]  O_fire_id;
  logic               O_trig_drop;

  modport master (
    output I_WEA, I_WRITE_ADDR, I_WRITE_DELAY, I_trig, I_wave_id,
    input  O_busy, O_fire, O_fire_id, O_trig_drop
  );

  modport slave (
    input  I_WEA, I_WRITE_ADDR, I_WRITE_DELAY, I_trig, I_wave_id,
    output O_busy, O_fire, O_fire_id, O_trig_drop
  );
endinterface

// File: rtl/wave_delay_trigger.sv
// Per-wave delay table plus a one-shot countdown that fires tagged with the wave ID.
// Define WAVE_DELAY_RETRIG_EN to let a busy trigger restart the schedule instead of dropping it.
//
// state | meaning
// IDLE  | waiting for a trigger
// READ  | table read in flight, counter loads next edge
// COUNT | counting down; fire pulse is out while counter = 0
module wave_delay_trigger #(
  parameter int ADDR_W  = 11,
  parameter int DELAY_W = 24
) (
  input logic                 I_clk_10M,
  input logic                 I_rst,
  wave_delay_trigger_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, COUNT} state_t;

  state_t              state;
  logic [DELAY_W-1:0]  mem [0:(1<<ADDR_W)-1];
  logic [DELAY_W-1:0]  rd_data;
  logic [DELAY_W-1:0]  count;
  logic                busy;
  logic                fire;
  logic [ADDR_W-1:0]   fire_id;
  logic                trig_drop;

  // Table is never reset; the read returns the pre-write value on a same-cycle collision.
  always_ff @(posedge I_clk_10M) begin
    if (bus.I_WEA)
      mem[bus.I_WRITE_ADDR] <= bus.I_WRITE_DELAY;
    if (bus.I_trig)
      rd_data <= mem[bus.I_wave_id];
  end

  // fire is computed one cycle early so it is high exactly while count sits at zero.
  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      fire      <= 1'b0;
      fire_id   <= '0;
      trig_drop <= 1'b0;
    end else begin
      trig_drop <= 1'b0;
      case (state)
        IDLE: begin
          fire <= 1'b0;
          if (bus.I_trig) begin
            fire_id <= bus.I_wave_id;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          count <= rd_data;
          fire  <= (rd_data == '0);
          state <= COUNT;
        end
        COUNT: begin
          if (count != '0) begin
            count <= count - 1'b1;
            fire  <= (count == DELAY_W'(1));
          end else begin
            fire  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && bus.I_trig) begin
`ifdef WAVE_DELAY_RETRIG_EN
        fire_id <= bus.I_wave_id;
        fire    <= 1'b0;
        busy    <= 1'b1;
        state   <= READ;
`else
        trig_drop <= 1'b1;
`endif
      end
    end
  end

  assign bus.O_busy      = busy;
  assign bus.O_fire      = fire;
  assign bus.O_fire_id   = fire_id;
  assign bus.O_trig_drop = trig_drop;
endmodule
